// File: rtl/mmu_pkg.sv
// Shared types and constants for the MMU address translator.
package mmu_pkg;

   localparam int unsigned VPN2_W     = 19;
   localparam int unsigned PFN_W      = 20;
   localparam int unsigned CACHE_W    = 3;
   localparam int unsigned TLB_ASID_W = 8;

   localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
   localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
   localparam logic [31:0] KSEG2_BASE = 32'hC000_0000;

   localparam logic [CACHE_W-1:0] CACHE_UNCACHED = 3'd2;

   typedef enum logic [1:0] {
      EXC_NONE    = 2'd0,
      EXC_REFILL  = 2'd1,
      EXC_INVALID = 2'd2,
      EXC_MOD     = 2'd3
   } exc_e;

   typedef struct packed {
      logic [VPN2_W-1:0]     vpn2;
      logic [TLB_ASID_W-1:0] asid;
      logic                  g;
      logic [PFN_W-1:0]      pfn0;
      logic [CACHE_W-1:0]    c0;
      logic                  d0;
      logic                  v0;
      logic [PFN_W-1:0]      pfn1;
      logic [CACHE_W-1:0]    c1;
      logic                  d1;
      logic                  v1;
   } tlb_entry_t;

endpackage

// File: rtl/mmu_tlb_xlat_tlb_match.sv
// Combinational fully associative TLB CAM; the lowest matching index wins.
module tlb_match
   import mmu_pkg::*;
#(
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
   input  tlb_entry_t            entries_i [ENTRIES],
   input  logic [VPN2_W-1:0]     vpn2_i,
   input  logic [TLB_ASID_W-1:0] asid_i,
   output logic                  hit_c_o,
   output logic [IDX_W-1:0]      idx_c_o
);

   // Scan downwards so the last assignment is the lowest matching index.
   always_comb begin
      hit_c_o = 1'b0;
      idx_c_o = '0;
      for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
         if ((entries_i[i].vpn2 == vpn2_i) &&
             (entries_i[i].g || (entries_i[i].asid == asid_i))) begin
            hit_c_o = 1'b1;
            idx_c_o = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/mmu_tlb_xlat.sv
// Registered virtual-to-physical translator: fixed kseg0/kseg1, TLB-mapped elsewhere.
// Optional performance counters are built when MMU_PERF_CNT_EN is defined.
module mmu_tlb_xlat
   import mmu_pkg::*;
#(
   parameter int unsigned TLB_ENTRIES = 16,
   parameter int unsigned ASID_W      = 8,
   parameter bit          USE_TLB     = 1'b1,
   parameter logic [31:0] UC_BASE     = 32'hBFAF_0000,
   parameter logic [31:0] UC_MASK     = 32'hFFFF_0000,
   localparam int unsigned IDX_W      = $clog2(TLB_ENTRIES)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [31:0]       req_vaddr,
   input  logic              req_store,
   input  logic [ASID_W-1:0] cur_asid,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_paddr,
   output logic              resp_uncache,
   output logic [1:0]        resp_exc,
`ifdef MMU_PERF_CNT_EN
   input  logic              perf_clr,
   output logic [31:0]       perf_hit,
   output logic [31:0]       perf_miss,
`endif
   input  logic              tlbw_en,
   input  logic [IDX_W-1:0]  tlbw_idx,
   input  tlb_entry_t        tlbw_entry
);

   tlb_entry_t         entries_q [TLB_ENTRIES];
   logic               tlb_hit;
   logic [IDX_W-1:0]   hit_idx;
   logic               accept;
   logic               is_kseg0;
   logic               is_kseg1;
   logic               in_window;
   logic [PFN_W-1:0]   pg_pfn;
   logic [CACHE_W-1:0] pg_c;
   logic               pg_d;
   logic               pg_v;

   logic               resp_valid_q;
   logic [31:0]        paddr_q, paddr_d;
   logic               uncache_q, uncache_d;
   exc_e               exc_q, exc_d;

   assign req_ready    = !resp_valid_q || resp_ready;
   assign accept       = req_valid && req_ready;
   assign resp_valid   = resp_valid_q;
   assign resp_paddr   = paddr_q;
   assign resp_uncache = uncache_q;
   assign resp_exc     = exc_q;

   // TLB entry storage; lookups in the write cycle see the old contents.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < int'(TLB_ENTRIES); i++) begin
            entries_q[i] <= '0;
         end
      end else if (tlbw_en) begin
         entries_q[tlbw_idx] <= tlbw_entry;
      end
   end

   tlb_match #(
      .ENTRIES (TLB_ENTRIES),
      .IDX_W   (IDX_W)
   ) u_match (
      .entries_i (entries_q),
      .vpn2_i    (req_vaddr[31:13]),
      .asid_i    (TLB_ASID_W'(cur_asid)),
      .hit_c_o   (tlb_hit),
      .idx_c_o   (hit_idx)
   );

   // Page select within the matched even/odd pair.
   always_comb begin
      if (req_vaddr[12]) begin
         pg_pfn = entries_q[hit_idx].pfn1;
         pg_c   = entries_q[hit_idx].c1;
         pg_d   = entries_q[hit_idx].d1;
         pg_v   = entries_q[hit_idx].v1;
      end else begin
         pg_pfn = entries_q[hit_idx].pfn0;
         pg_c   = entries_q[hit_idx].c0;
         pg_d   = entries_q[hit_idx].d0;
         pg_v   = entries_q[hit_idx].v0;
      end
   end

   // Segment decode, exception priority and uncached attribute.
   always_comb begin
      is_kseg0  = (req_vaddr >= KSEG0_BASE) && (req_vaddr < KSEG1_BASE);
      is_kseg1  = (req_vaddr >= KSEG1_BASE) && (req_vaddr < KSEG2_BASE);
      in_window = (UC_MASK != '0) && ((req_vaddr & UC_MASK) == UC_BASE);
      paddr_d   = req_vaddr;
      uncache_d = 1'b0;
      exc_d     = EXC_NONE;
      if (is_kseg0) begin
         paddr_d   = req_vaddr - KSEG0_BASE;
         uncache_d = in_window;
      end else if (is_kseg1) begin
         paddr_d   = req_vaddr - KSEG1_BASE;
         uncache_d = 1'b1;
      end else if (!USE_TLB) begin
         uncache_d = in_window;
      end else if (!tlb_hit) begin
         exc_d = EXC_REFILL;
      end else if (!pg_v) begin
         exc_d = EXC_INVALID;
      end else if (req_store && !pg_d) begin
         exc_d = EXC_MOD;
      end else begin
         paddr_d   = {pg_pfn, req_vaddr[11:0]};
         uncache_d = (pg_c == CACHE_UNCACHED) || in_window;
      end
   end

   // Response register: loads on accept, holds under backpressure.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         resp_valid_q <= 1'b0;
         paddr_q      <= '0;
         uncache_q    <= 1'b0;
         exc_q        <= EXC_NONE;
      end else if (accept) begin
         resp_valid_q <= 1'b1;
         paddr_q      <= paddr_d;
         uncache_q    <= uncache_d;
         exc_q        <= exc_d;
      end else if (resp_ready) begin
         resp_valid_q <= 1'b0;
      end
   end

`ifdef MMU_PERF_CNT_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;
   logic        cnt_ev;

   assign cnt_ev    = accept && USE_TLB && !is_kseg0 && !is_kseg1;
   assign perf_hit  = hit_cnt_q;
   assign perf_miss = miss_cnt_q;

   // Saturating hit/miss counters; clear wins over increment.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (perf_clr) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (cnt_ev) begin
         if (tlb_hit) begin
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
         end else begin
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mmu_tlb_xlat.sv
// Scoreboard bench for mmu_tlb_xlat: directed requests, queued expectations, negedge monitor.
module tb_mmu_tlb_xlat;
   import mmu_pkg::*;

   typedef struct packed {
      logic [31:0] paddr;
      logic        uc;
      logic [1:0]  exc;
      logic [7:0]  tag;
   } exp_t;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_vaddr;
   logic        req_store;
   logic [7:0]  cur_asid;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_paddr;
   logic        resp_uncache;
   logic [1:0]  resp_exc;
   logic        tlbw_en;
   logic [3:0]  tlbw_idx;
   tlb_entry_t  tlbw_entry;
`ifdef MMU_PERF_CNT_EN
   logic        perf_clr;
   logic [31:0] perf_hit;
   logic [31:0] perf_miss;
`endif

   int   total = 0;
   int   bad   = 0;
   exp_t q[$];

   mmu_tlb_xlat dut (
      .clk          (clk),
      .resetn       (resetn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_vaddr    (req_vaddr),
      .req_store    (req_store),
      .cur_asid     (cur_asid),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_paddr   (resp_paddr),
      .resp_uncache (resp_uncache),
      .resp_exc     (resp_exc),
`ifdef MMU_PERF_CNT_EN
      .perf_clr     (perf_clr),
      .perf_hit     (perf_hit),
      .perf_miss    (perf_miss),
`endif
      .tlbw_en      (tlbw_en),
      .tlbw_idx     (tlbw_idx),
      .tlbw_entry   (tlbw_entry)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: every delivered response is checked against the queue head.
   always @(negedge clk) begin
      if (resetn && resp_valid && resp_ready) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL resp_unexpected: got paddr=%h uc=%0d exc=%0d, none expected",
                     resp_paddr, resp_uncache, resp_exc);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (resp_paddr !== e.paddr || resp_uncache !== e.uc || resp_exc !== e.exc) begin
               bad++;
               $display("FAIL resp_t%0d: got paddr=%h uc=%0d exc=%0d, want paddr=%h uc=%0d exc=%0d",
                        e.tag, resp_paddr, resp_uncache, resp_exc, e.paddr, e.uc, e.exc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   task automatic expect_resp(input logic [7:0] tag, input logic [31:0] ep,
                              input logic eu, input logic [1:0] ee);
      exp_t e;
      e.paddr = ep;
      e.uc    = eu;
      e.exc   = ee;
      e.tag   = tag;
      q.push_back(e);
   endtask

   task automatic send(input logic [7:0] tag, input logic [31:0] a, input logic st,
                       input logic [7:0] asid, input logic [31:0] ep,
                       input logic eu, input logic [1:0] ee);
      int n;
      @(posedge clk); #1;
      req_vaddr = a;
      req_store = st;
      cur_asid  = asid;
      req_valid = 1'b1;
      expect_resp(tag, ep, eu, ee);
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout_t%0d: req_ready=%0d, want 1", tag, req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   function automatic tlb_entry_t mk(input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
                                     input logic [19:0] pfn0, input logic [2:0] c0,
                                     input logic d0, input logic v0,
                                     input logic [19:0] pfn1, input logic [2:0] c1,
                                     input logic d1, input logic v1);
      tlb_entry_t e;
      e.vpn2 = vpn2; e.asid = asid; e.g = g;
      e.pfn0 = pfn0; e.c0 = c0; e.d0 = d0; e.v0 = v0;
      e.pfn1 = pfn1; e.c1 = c1; e.d1 = d1; e.v1 = v1;
      return e;
   endfunction

   task automatic wr(input logic [3:0] idx, input tlb_entry_t e);
      @(posedge clk); #1;
      tlbw_en    = 1'b1;
      tlbw_idx   = idx;
      tlbw_entry = e;
      @(posedge clk); #1;
      tlbw_en    = 1'b0;
   endtask

   initial begin
      int n;
      req_valid  = 1'b0;
      req_vaddr  = '0;
      req_store  = 1'b0;
      cur_asid   = '0;
      resp_ready = 1'b1;
      tlbw_en    = 1'b0;
      tlbw_idx   = '0;
      tlbw_entry = '0;
`ifdef MMU_PERF_CNT_EN
      perf_clr   = 1'b0;
`endif
      resetn = 1'b1;
      #1 resetn = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid",   32'(resp_valid),   32'd0);
      chk("rst_paddr",   resp_paddr,        32'd0);
      chk("rst_uncache", 32'(resp_uncache), 32'd0);
      chk("rst_exc",     32'(resp_exc),     32'd0);
      chk("rst_ready",   32'(req_ready),    32'd1);
      @(posedge clk); #1 resetn = 1'b1;

      // Fixed segments
      send(8'd1, 32'h9FC0_0100, 1'b0, 8'd0, 32'h1FC0_0100, 1'b0, 2'd0);
      send(8'd2, 32'hBFAF_F000, 1'b0, 8'd0, 32'h1FAF_F000, 1'b1, 2'd0);
      send(8'd3, 32'hBFD0_0000, 1'b0, 8'd0, 32'h1FD0_0000, 1'b1, 2'd0);
      // Empty TLB refills in kuseg, kseg2, kseg3
      send(8'd4, 32'h0040_0000, 1'b0, 8'd0, 32'h0040_0000, 1'b0, 2'd1);
      send(8'd5, 32'hC000_0000, 1'b0, 8'd0, 32'hC000_0000, 1'b0, 2'd1);
      send(8'd6, 32'hE000_1234, 1'b0, 8'd0, 32'hE000_1234, 1'b0, 2'd1);

      // Global entry, clean page: load hits, store raises modified
      wr(4'd3, mk(19'h00200, 8'd0, 1'b1, 20'h01234, 3'd3, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
      send(8'd7, 32'h0040_0010, 1'b0, 8'd0, 32'h0123_4010, 1'b0, 2'd0);
      send(8'd8, 32'h0040_0010, 1'b1, 8'd0, 32'h0040_0010, 1'b0, 2'd3);
      send(8'd9, 32'h0040_1000, 1'b0, 8'd0, 32'h0040_1000, 1'b0, 2'd2);

      // ASID-private entry with an invalid odd page
      wr(4'd5, mk(19'h00001, 8'd7, 1'b0, 20'h00055, 3'd2, 1'b1, 1'b1, 20'h0, 3'd3, 1'b1, 1'b0));
      send(8'd10, 32'h0000_3000, 1'b0, 8'd7, 32'h0000_3000, 1'b0, 2'd2);
      send(8'd11, 32'h0000_3000, 1'b0, 8'd8, 32'h0000_3000, 1'b0, 2'd1);
      send(8'd12, 32'h0000_2004, 1'b1, 8'd7, 32'h0005_5004, 1'b1, 2'd0);

      // Odd page hit with uncached attribute
      wr(4'd7, mk(19'h00600, 8'd0, 1'b1, 20'h0, 3'd3, 1'b0, 1'b0, 20'h00777, 3'd2, 1'b1, 1'b1));
      send(8'd13, 32'h00C0_1008, 1'b1, 8'd0, 32'h0077_7008, 1'b1, 2'd0);

      // Duplicate match: index 1 beats index 3
      wr(4'd1, mk(19'h00200, 8'd0, 1'b1, 20'h00999, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0));
      send(8'd14, 32'h0040_0010, 1'b1, 8'd0, 32'h0099_9010, 1'b0, 2'd0);

      // Backpressure: A accepted, B held off for three cycles
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_store  = 1'b0;
      req_vaddr  = 32'h8000_1000;
      expect_resp(8'd15, 32'h0000_1000, 1'b0, 2'd0);
      @(posedge clk); #1;
      req_vaddr  = 32'hA000_2000;
      expect_resp(8'd16, 32'h0000_2000, 1'b1, 2'd0);
      repeat (3) begin
         @(negedge clk);
         chk("bp_ready", 32'(req_ready),  32'd0);
         chk("bp_valid", 32'(resp_valid), 32'd1);
         chk("bp_paddr", resp_paddr,      32'h0000_1000);
      end
      @(posedge clk); #1 resp_ready = 1'b1;
      @(posedge clk); #1 req_valid  = 1'b0;

      // Write and lookup of the same VPN in one cycle: old contents used
      @(posedge clk); #1;
      tlbw_en    = 1'b1;
      tlbw_idx   = 4'd0;
      tlbw_entry = mk(19'h00800, 8'd0, 1'b1, 20'h0ABCD, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
      req_valid  = 1'b1;
      req_vaddr  = 32'h0100_0020;
      expect_resp(8'd17, 32'h0100_0020, 1'b0, 2'd1);
      @(posedge clk); #1;
      tlbw_en    = 1'b0;
      req_valid  = 1'b0;
      send(8'd18, 32'h0100_0020, 1'b0, 8'd0, 32'h0ABC_D020, 1'b0, 2'd0);

      // Reset during a stall drops the pending result and clears the TLB
      @(posedge clk); #1;
      resp_ready = 1'b0;
      req_valid  = 1'b1;
      req_vaddr  = 32'h9000_0000;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      chk("stall_valid", 32'(resp_valid), 32'd1);
      @(posedge clk); #1;
      resetn = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(resp_valid), 32'd0);
      @(posedge clk); #1;
      resetn     = 1'b1;
      resp_ready = 1'b1;
      send(8'd19, 32'h0100_0020, 1'b0, 8'd0, 32'h0100_0020, 1'b0, 2'd1);

      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      chk("queue_drained", 32'(q.size()), 32'd0);
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
